// File: rtl/qk_prune_stream_tx.sv
// Head-prune statistics transmit side: pairs Q*K tiles onto res1/res2 with sum_enable, then pulses compare_flag.
// Optional per-head pair counter and overflow flag are built only when PAIR_CNT_EN is defined.
module qk_prune_stream_tx #(
   parameter int WIDTH     = 8,
   parameter int DRAIN_CYC = 2,
   parameter int CNT_W     = 6,
   parameter int MAX_PAIRS = 16
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  tile_valid,
   output logic                  tile_ready,
   input  logic                  tile_last,
   input  logic [32*WIDTH-1:0]   tile_data,
   input  logic                  head_abort,
   output logic                  sum_enable,
   output logic                  compare_flag,
   output logic [32*WIDTH-1:0]   res1_bus,
   output logic [32*WIDTH-1:0]   res2_bus,
   output logic                  head_done,
   output logic [CNT_W-1:0]      pair_count,
   output logic                  pair_ovf
);

   localparam int TW = 32*WIDTH;
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {IDLE, HOLD, EMIT, DRAIN, CMP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   buf1_q, buf1_d, buf2_q, buf2_d;
   logic [TW-1:0]   res1_q, res1_d, res2_q, res2_d;
   logic            last_q, last_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            se_q, se_d, cmp_q, cmp_d;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q <= IDLE;
         buf1_q  <= '0;
         buf2_q  <= '0;
         res1_q  <= '0;
         res2_q  <= '0;
         last_q  <= 1'b0;
         drain_q <= '0;
         se_q    <= 1'b0;
         cmp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf1_q  <= buf1_d;
         buf2_q  <= buf2_d;
         res1_q  <= res1_d;
         res2_q  <= res2_d;
         last_q  <= last_d;
         drain_q <= drain_d;
         se_q    <= se_d;
         cmp_q   <= cmp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      buf1_d     = buf1_q;
      buf2_d     = buf2_q;
      res1_d     = res1_q;
      res2_d     = res2_q;
      last_d     = last_q;
      drain_d    = drain_q;
      se_d       = 1'b0;
      cmp_d      = 1'b0;
      tile_ready = 1'b0;
      // Abort takes priority: ready stays low so a concurrent tile is never consumed.
      if (head_abort) begin
         state_d = IDLE;
         buf1_d  = '0;
         buf2_d  = '0;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tile_ready = 1'b1;
               if (tile_valid) begin
                  buf1_d  = tile_data;
                  last_d  = tile_last;
                  if (tile_last) begin
                     buf2_d  = '0;
                     state_d = EMIT;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               tile_ready = 1'b1;
               if (tile_valid) begin
                  buf2_d  = tile_data;
                  last_d  = tile_last;
                  state_d = EMIT;
               end
            end
            EMIT: begin
               res1_d = buf1_q;
               res2_d = buf2_q;
               se_d   = 1'b1;
               if (last_q) begin
                  drain_d = DW'(DRAIN_CYC - 1);
                  state_d = DRAIN;
               end else begin
                  state_d = IDLE;
               end
            end
            DRAIN: begin
               if (drain_q == '0) state_d = CMP;
               else               drain_d = drain_q - 1'b1;
            end
            CMP: begin
               cmp_d   = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign sum_enable   = se_q;
   assign compare_flag = cmp_q;
   assign head_done    = cmp_q;
   assign res1_bus     = res1_q;
   assign res2_bus     = res2_q;

`ifdef PAIR_CNT_EN
   logic             emit_ev, cmp_ev;
   logic [CNT_W-1:0] pc_q;
   logic             ovf_q;

   assign emit_ev = (state_q == EMIT) && !head_abort;
   assign cmp_ev  = (state_q == CMP) && !head_abort;

   // Overflow is sticky across heads; only abort or reset clears it.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         pc_q  <= '0;
         ovf_q <= 1'b0;
      end else if (head_abort) begin
         pc_q  <= '0;
         ovf_q <= 1'b0;
      end else if (emit_ev) begin
         if (pc_q != '1) pc_q <= pc_q + 1'b1;
         if (pc_q == CNT_W'(MAX_PAIRS)) ovf_q <= 1'b1;
      end else if (cmp_ev) begin
         pc_q <= '0;
      end
   end

   assign pair_count = pc_q;
   assign pair_ovf   = ovf_q;
`else
   assign pair_count = '0;
   assign pair_ovf   = 1'b0;
`endif

endmodule
